alu_byte_sequencer: RTL

- Host-side byte-serial front end for the 8-bit ALU core.
- Collects an opcode and full 8-bit A/B operands over an 8-bit data bus using a write strobe, and drives them to the ALU.
- Captures the ALU result and flags, then returns them byte by byte on an 8-bit output bus.
- Sits between the chip pins (ui_in/uo_out) and alu_8bit, lifting the pin-count limit that otherwise truncates operands to 3 and 2 bits.

---
 rtl/alu_byte_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_byte_sequencer.sv
// Byte-serial host front end for alu_8bit: collects opcode/A/B on data_in strobes,
// then returns the result byte and the flag byte over data_out.
//
// state  | meaning
// S_OP   | waiting for opcode byte (bit 7 set = resync/no-op)
// S_A    | waiting for operand A
// S_B    | waiting for operand B
// S_EXEC | one cycle to capture ALU result and flags
// S_RES  | result byte on data_out, next strobe advances
// S_FLAG | flag byte on data_out, next strobe returns to S_OP
module alu_byte_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       wr_strobe,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       tmo
);

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4,
        S_FLAG = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic             strobe_q;
    logic             stb_edge;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       res_q, flag_q;
    logic             tmo_q, tmo_nxt;
    logic             load_sel, load_a, load_b, capture;
    logic             timeout_hit;

    assign stb_edge    = wr_strobe & ~strobe_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter defaults to clear so that entry to S_A and every accepted byte restart it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        tmo_nxt   = 1'b0;
        load_sel  = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_OP: begin
                if (stb_edge && !data_in[7]) begin
                    load_sel  = 1'b1;
                    state_nxt = S_A;
                end
            end
            S_A: begin
                if (stb_edge) begin
                    load_a    = 1'b1;
                    state_nxt = S_B;
                end else if (timeout_hit) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = S_OP;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_B: begin
                if (stb_edge) begin
                    load_b    = 1'b1;
                    state_nxt = S_EXEC;
                end else if (timeout_hit) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = S_OP;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                capture   = 1'b1;
                state_nxt = S_RES;
            end
            S_RES: begin
                if (stb_edge) state_nxt = S_FLAG;
            end
            S_FLAG: begin
                if (stb_edge) state_nxt = S_OP;
            end
            default: state_nxt = S_OP;
        endcase
    end

    // Strobe history tracks the pin even while disabled, so edges during ena=0 are lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_OP;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            res_q    <= '0;
            flag_q   <= '0;
        end else begin
            strobe_q <= wr_strobe;
            if (ena) begin
                state <= state_nxt;
                cnt_q <= cnt_nxt;
                tmo_q <= tmo_nxt;
                if (load_sel) alu_sel <= data_in[2:0];
                if (load_a)   alu_a   <= data_in;
                if (load_b)   alu_b   <= data_in;
                if (capture) begin
                    res_q  <= alu_result;
                    flag_q <= {6'b0, (alu_result == 8'h00), alu_cout};
                end
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (state)
            S_RES:   data_out = res_q;
            S_FLAG:  data_out = flag_q;
            default: data_out = 8'h00;
        endcase
    end

    assign busy = (state == S_A) || (state == S_B) || (state == S_EXEC);
    assign done = (state == S_RES) || (state == S_FLAG);
    assign tmo  = tmo_q;

endmodule
